// File: rtl/stream_packer_if.sv
// Handshake bundle for stream_packer.
// Input side: i_in/i_prec/i_valid/i_flush with o_ready back-pressure.
// Output side: o_out/o_valid/o_last/o_flush_done with i_ready back-pressure.
// The master modport belongs to the environment that feeds data and drains rows.
// The slave modport belongs to the packer.
interface stream_packer_if #(
  parameter int BIT_WIDTH = 16,
  parameter int PREC_BITS = 5
);
  logic [BIT_WIDTH-1:0] i_in;
  logic [PREC_BITS-1:0] i_prec;
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_flush;
  logic [BIT_WIDTH-1:0] o_out;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_last;
  logic                 o_flush_done;

  modport master (
    output i_in, i_prec, i_valid, i_flush, i_ready,
    input  o_ready, o_out, o_valid, o_last, o_flush_done
  );

  modport slave (
    input  i_in, i_prec, i_valid, i_flush, i_ready,
    output o_ready, o_out, o_valid, o_last, o_flush_done
  );
endinterface

// File: rtl/stream_packer.sv
// stream_packer: packs variable-precision values LSB-first into BIT_WIDTH-bit rows.
// Each accepted value contributes its low p bits directly after the previous value.
// i_flush closes the current partial row, emitting it zero-padded with o_last set.
// The flush then ends with a one-cycle o_flush_done pulse.
// Optional feature: define STREAM_PACKER_WORD_CNT_EN to add the o_word_cnt row counter.
module stream_packer #(
  parameter int BIT_WIDTH = 16,
  parameter int PREC_BITS = 5,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  stream_packer_if.slave      bus
`ifdef STREAM_PACKER_WORD_CNT_EN
  ,
  output logic [CNT_BITS-1:0] o_word_cnt
`endif
);

  localparam int RW = 2 * BIT_WIDTH;
  localparam int FW = $clog2(RW);

  typedef enum logic [0:0] {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [RW-1:0]   r;
  logic [RW-1:0]   r_next;
  logic [FW-1:0]   f;
  logic [FW-1:0]   f_next;
  logic [PREC_BITS-1:0] p_eff;
  logic [RW-1:0]   in_wide;
  logic            full;
  logic            partial;
  logic            valid_c;
  logic            ready_c;
  logic            last_c;
  logic            done_c;
  logic            push;
  logic            pop;

  // Keep only the low p bits of d, zero-extended to the packing register width.
  function automatic logic [RW-1:0] mask_value(input logic [BIT_WIDTH-1:0] d,
                                               input logic [PREC_BITS-1:0] p);
    logic [RW-1:0] m;
    m = {RW{1'b0}};
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (i < int'(p)) begin
        m[i] = d[i];
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Resolve the effective precision (0 or oversize means full width) and mask the input.
  always_comb begin
    p_eff = bus.i_prec;
    if ((bus.i_prec == {PREC_BITS{1'b0}}) || (bus.i_prec > PREC_BITS'(BIT_WIDTH))) begin
      p_eff = PREC_BITS'(BIT_WIDTH);
    end else begin
      p_eff = bus.i_prec;
    end
    in_wide = mask_value(bus.i_in, p_eff);
  end

  // Next-state, packing datapath and handshake decode.
  always_comb begin
    state_next = state;
    r_next     = r;
    f_next     = f;
    valid_c    = 1'b0;
    ready_c    = 1'b0;
    last_c     = 1'b0;
    done_c     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    full       = (f >= FW'(BIT_WIDTH));
    partial    = (f != {FW{1'b0}}) && !full;
    case (state)
      PACK: begin
        valid_c = full;
        // A full row leaving this cycle frees room for the incoming value.
        ready_c = !full || bus.i_ready;
        push    = bus.i_valid && ready_c;
        pop     = valid_c && bus.i_ready;
        if (push && pop) begin
          r_next = (r >> BIT_WIDTH) | (in_wide << (f - FW'(BIT_WIDTH)));
          f_next = f - FW'(BIT_WIDTH) + FW'(p_eff);
        end else if (push) begin
          r_next = r | (in_wide << f);
          f_next = f + FW'(p_eff);
        end else if (pop) begin
          r_next = r >> BIT_WIDTH;
          f_next = f - FW'(BIT_WIDTH);
        end else begin
          r_next = r;
          f_next = f;
        end
        if (bus.i_flush && ready_c) begin
          state_next = FLUSH;
        end else begin
          state_next = PACK;
        end
      end
      FLUSH: begin
        ready_c = 1'b0;
        if (full) begin
          valid_c = 1'b1;
          last_c  = (f == FW'(BIT_WIDTH));
          pop     = bus.i_ready;
          if (pop) begin
            r_next = r >> BIT_WIDTH;
            f_next = f - FW'(BIT_WIDTH);
          end else begin
            r_next = r;
            f_next = f;
          end
        end else if (partial) begin
          // Bits above f are already zero, so the low half is the padded row.
          valid_c = 1'b1;
          last_c  = 1'b1;
          pop     = bus.i_ready;
          if (pop) begin
            r_next = {RW{1'b0}};
            f_next = {FW{1'b0}};
          end else begin
            r_next = r;
            f_next = f;
          end
        end else begin
          done_c     = 1'b1;
          state_next = PACK;
        end
      end
      default: begin
        state_next = PACK;
        r_next     = {RW{1'b0}};
        f_next     = {FW{1'b0}};
      end
    endcase
  end

  // State, packing register and fill count; rst discards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PACK;
      r     <= {RW{1'b0}};
      f     <= {FW{1'b0}};
    end else begin
      state <= state_next;
      r     <= r_next;
      f     <= f_next;
    end
  end

`ifdef STREAM_PACKER_WORD_CNT_EN
  // Count emitted rows; wraps naturally at 2^CNT_BITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_word_cnt <= {CNT_BITS{1'b0}};
    end else if (pop) begin
      o_word_cnt <= o_word_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      o_word_cnt <= o_word_cnt;
    end
  end
`endif

  assign bus.o_out        = r[BIT_WIDTH-1:0];
  assign bus.o_valid      = valid_c;
  assign bus.o_ready      = ready_c;
  assign bus.o_last       = last_c;
  assign bus.o_flush_done = done_c;

endmodule
